multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/bubble_ctrl_pkg.sv | 24 ++
 rtl/ctrl_decode.sv | 30 +++
 rtl/multicycle_controller.sv | 94 +++++++++
 tb/tb_multicycle_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bubble_ctrl_pkg.sv
// bubble_ctrl_pkg: opcode constants, FSM state encoding and decode bundle shared by the
// multicycle controller and its decoder.
package bubble_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  typedef struct packed {
    logic r;
    logic i;
    logic j;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic halt;
    logic legal;
  } dec_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode decode of the held instruction register.
module ctrl_decode import bubble_ctrl_pkg::*; #(
  parameter int INSTR_W = 32,
  parameter int OP_W    = 6
) (
  input  logic [INSTR_W-1:0] ir_i,
  output dec_t               dec_o,
  output logic [OP_W-1:0]    alu_op_o
);
  logic [OP_W-1:0] op, fn;
  logic r, addi, lw, sw, beq, bne, j, halt, i;
  logic unused_mid;
  assign unused_mid = ^ir_i[INSTR_W-OP_W-1:OP_W];
  always_comb begin
    op = ir_i[INSTR_W-1 -: OP_W];
    fn = ir_i[OP_W-1:0];
    r = op == OP_W'(OP_RTYPE);
    addi = op == OP_W'(OP_ADDI);
    lw = op == OP_W'(OP_LW);
    sw = op == OP_W'(OP_SW);
    beq = op == OP_W'(OP_BEQ);
    bne = op == OP_W'(OP_BNE);
    j = op == OP_W'(OP_J);
    halt = op == OP_W'(OP_HALT);
    i = addi | lw | sw | beq | bne;
    dec_o = '{r: r, i: i, j: j, lw: lw, sw: sw, beq: beq, bne: bne, halt: halt,
              legal: r | i | j | halt};
    alu_op_o = r ? fn : i ? op : '0;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeouts and retire count.
module multicycle_controller import bubble_ctrl_pkg::*; #(
  parameter int INSTR_W = 32,
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  output logic               imem_req,
  input  logic               imem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  input  logic               alu_zero,
  output logic [OP_W-1:0]    alu_op,
  output logic [OP_W-1:0]    funct,
  output logic               use_alu_r,
  output logic               use_alu_i,
  output logic               use_alu_j,
  output logic               branch,
  output logic               jump,
  output logic               pc_we,
  output logic               ir_we,
  output logic               reg_we,
  output logic               illegal,
  output logic               bus_err,
  output logic               halted,
  output logic [CNT_W-1:0]   instret
);
  state_e             state_q;
  logic               run_q;
  logic [INSTR_W-1:0] ir_q;
  logic [7:0]         wait_q;
  logic [CNT_W-1:0]   instret_q;
  dec_t               dec;
  logic [OP_W-1:0]    dec_alu_op;
  logic in_fetch, in_mem, held, ack, timeout, take, retire;
  ctrl_decode #(.INSTR_W(INSTR_W), .OP_W(OP_W)) u_decode (
    .ir_i(ir_q),
    .dec_o(dec),
    .alu_op_o(dec_alu_op)
  );
  // run_q keeps imem_req low while reset is held; fetching starts one edge after release.
  always_comb begin
    in_fetch = run_q && state_q == S_FETCH;
    in_mem = state_q == S_MEM;
    held = state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB};
    ack = in_fetch ? imem_ack : in_mem & dmem_ack;
    timeout = (in_fetch | in_mem) & !ack & (wait_q == 8'(TIMEOUT - 1));
    take = (dec.beq & alu_zero) | (dec.bne & !alu_zero);
    imem_req = in_fetch;
    dmem_req = in_mem;
    dmem_we = in_mem & dec.sw;
    use_alu_r = held & dec.r;
    use_alu_i = held & dec.i;
    use_alu_j = held & dec.j;
    alu_op = held ? dec_alu_op : '0;
    funct = held ? ir_q[OP_W-1:0] : '0;
    branch = state_q == S_EXEC && (dec.beq | dec.bne);
    jump = state_q == S_DECODE && dec.j;
    ir_we = in_fetch & imem_ack;
    pc_we = ir_we | jump | (branch & take);
    reg_we = state_q == S_WB;
    illegal = state_q == S_DECODE && !dec.legal;
    bus_err = timeout;
    halted = state_q == S_HALT;
    retire = jump | branch | reg_we | (in_mem & dmem_ack & dec.sw);
  end
  assign instret = instret_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      run_q <= 1'b0;
      ir_q <= '0;
      wait_q <= '0;
      instret_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (ir_we) ir_q <= instr;
      if (retire) instret_q <= instret_q + CNT_W'(1);
      wait_q <= ((in_fetch | in_mem) && !ack && !timeout) ? wait_q + 8'd1 : '0;
      case (state_q)
        S_FETCH: state_q <= ir_we ? S_DECODE : S_FETCH;
        S_DECODE: state_q <= dec.halt ? S_HALT : (dec.legal && !dec.j) ? S_EXEC : S_FETCH;
        S_EXEC: state_q <= (dec.lw | dec.sw) ? S_MEM : (dec.beq | dec.bne) ? S_FETCH : S_WB;
        S_MEM: state_q <= dmem_ack ? (dec.lw ? S_WB : S_FETCH) : timeout ? S_FETCH : S_MEM;
        S_WB: state_q <= S_FETCH;
        default: state_q <= state_q;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-instruction cycle traces built from the instruction-level rules,
// driven directed and randomized, compared cycle by cycle.
module tb_multicycle_controller;
  localparam int TO = 15;
  localparam int CW = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic imem_ack = 1'b0, dmem_ack = 1'b0, alu_zero = 1'b0;
  logic imem_req, dmem_req, dmem_we, use_alu_r, use_alu_i, use_alu_j;
  logic branch, jump, pc_we, ir_we, reg_we, illegal, bus_err, halted;
  logic [5:0] alu_op, funct;
  logic [CW-1:0] instret;
  always #5 clk = ~clk;
  multicycle_controller #(.INSTR_W(32), .OP_W(6), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .alu_zero(alu_zero),
    .alu_op(alu_op), .funct(funct), .use_alu_r(use_alu_r), .use_alu_i(use_alu_i),
    .use_alu_j(use_alu_j), .branch(branch), .jump(jump), .pc_we(pc_we), .ir_we(ir_we),
    .reg_we(reg_we), .illegal(illegal), .bus_err(bus_err), .halted(halted), .instret(instret)
  );
  typedef struct packed {
    logic ireq, dreq, dwe, ur, ui, uj;
    logic [5:0] aop, fn;
    logic br, jmp, pcwe, irwe, regwe, ill, berr, hlt;
  } obs_t;
  typedef struct packed {logic iack, dack, z; obs_t e;} vec_t;
  typedef struct {string nm; logic [31:0] in; int ia; bit z; int da;} case_t;
  vec_t tbl[$];
  int ret;
  logic [CW-1:0] cnt = '0;
  int tot = 0, pass_n = 0;
  case_t dir[14];
  function automatic obs_t sample();
    obs_t o;
    o = '{ireq: imem_req, dreq: dmem_req, dwe: dmem_we, ur: use_alu_r, ui: use_alu_i,
          uj: use_alu_j, aop: alu_op, fn: funct, br: branch, jmp: jump, pcwe: pc_we,
          irwe: ir_we, regwe: reg_we, ill: illegal, berr: bus_err, hlt: halted};
    return o;
  endfunction
  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
    tot++;
    if (got === want) pass_n++;
    else $display("FAIL %s row %0d: got %h expected %h", nm, k, got, want);
  endtask
  function automatic vec_t row(input bit z);
    vec_t v;
    v = '0;
    v.iack = 1'($urandom);
    v.dack = 1'($urandom);
    v.z = z;
    return v;
  endfunction
  // Expected trace of one instruction from fetch to retire (or abort), one row per cycle.
  function automatic void plan(input logic [31:0] in, input int ia, input bit z, input int da);
    logic [5:0] op, fn;
    bit r, i, j, lw, sw, br, hlt, take;
    obs_t b;
    vec_t v;
    op = in[31:26];
    fn = in[5:0];
    r = op == 6'h00;
    lw = op == 6'h23;
    sw = op == 6'h2B;
    br = op == 6'h04 || op == 6'h05;
    i = lw | sw | br | (op == 6'h08);
    j = op == 6'h02;
    hlt = op == 6'h3F;
    take = (op == 6'h04) ? z : !z;
    tbl.delete();
    ret = 0;
    for (int c = 1; c <= TO; c++) begin
      v = row(1'($urandom));
      v.iack = c == ia;
      v.e.ireq = 1;
      v.e.irwe = v.iack;
      v.e.pcwe = v.iack;
      v.e.berr = !v.iack && c == TO;
      tbl.push_back(v);
      if (v.iack) break;
      if (c == TO) return;
    end
    b = '0;
    b.ur = r;
    b.ui = i;
    b.uj = j;
    b.aop = r ? fn : i ? op : 6'd0;
    b.fn = fn;
    v = row(1'($urandom));
    v.e = b;
    v.e.jmp = j;
    v.e.pcwe = j;
    v.e.ill = !(r | i | j | hlt);
    tbl.push_back(v);
    if (j) begin ret = 1; return; end
    if (hlt) begin
      for (int c = 0; c < 20; c++) begin
        v = row(1'($urandom));
        v.iack = 1;
        v.dack = 1;
        v.e.hlt = 1;
        tbl.push_back(v);
      end
      return;
    end
    if (!(r | i)) return;
    v = row(z);
    v.e = b;
    v.e.br = br;
    v.e.pcwe = br & take;
    tbl.push_back(v);
    if (br) begin ret = 1; return; end
    if (lw | sw) begin
      for (int c = 1; c <= TO; c++) begin
        v = row(1'($urandom));
        v.dack = c == da;
        v.e = b;
        v.e.dreq = 1;
        v.e.dwe = sw;
        v.e.berr = !v.dack && c == TO;
        tbl.push_back(v);
        if (v.dack && sw) begin ret = 1; return; end
        if (v.dack) break;
        if (c == TO) return;
      end
    end
    v = row(1'($urandom));
    v.e = b;
    v.e.regwe = 1;
    tbl.push_back(v);
    ret = 1;
  endfunction
  task automatic go(input string nm, input logic [31:0] in, input int nmax);
    foreach (tbl[k]) begin
      if (k >= nmax) return;
      @(posedge clk);
      #1;
      instr = tbl[k].iack ? in : $urandom;
      imem_ack = tbl[k].iack;
      dmem_ack = tbl[k].dack;
      alu_zero = tbl[k].z;
      @(negedge clk);
      chk(nm, k, 32'(sample()), 32'(tbl[k].e));
      chk({nm, "_instret"}, k, 32'(instret), 32'(cnt));
    end
    cnt += CW'(ret);
  endtask
  task automatic do_reset();
    rst_n = 0;
    imem_ack = 0;
    dmem_ack = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 0, 32'(sample()), 0);
    chk("reset_instret", 0, 32'(instret), 0);
    cnt = '0;
    rst_n = 1;
  endtask
  initial begin
    logic [5:0] op;
    logic [31:0] in;
    int ia, da;
    obs_t e;
    dir = '{
      '{"add", 32'h00221020, 2, 0, 0}, '{"bne_nz", 32'h14410001, 1, 0, 0},
      '{"bne_z", 32'h14410001, 1, 1, 0}, '{"lw_timeout", 32'h8C220004, 1, 0, 0},
      '{"lw_ack15", 32'h8C220004, 1, 0, 15}, '{"sw", 32'hAC220004, 3, 0, 2},
      '{"addi", 32'h20220005, 1, 0, 0}, '{"beq_taken", 32'h10220003, 1, 1, 0},
      '{"beq_not", 32'h10220003, 1, 0, 0}, '{"illegal", 32'hCC000000, 1, 0, 0},
      '{"jump", 32'h08000400, 1, 0, 0}, '{"fetch_timeout", 32'h00221020, 0, 0, 0},
      '{"fetch_ack15", 32'h00221020, 15, 0, 0}, '{"lw_ack1", 32'h8C220004, 1, 0, 1}
    };
    do_reset();
    foreach (dir[n]) begin
      plan(dir[n].in, dir[n].ia, dir[n].z, dir[n].da);
      go(dir[n].nm, dir[n].in, 1000);
    end
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0: op = 6'h00;
        1: op = 6'h08;
        2: op = 6'h23;
        3: op = 6'h2B;
        4: op = 6'h04;
        5: op = 6'h05;
        6: op = 6'h02;
        default: begin
          op = 6'($urandom);
          while (op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F})
            op = 6'($urandom);
        end
      endcase
      in = {op, 26'($urandom)};
      ia = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 1) : $urandom_range(1, 4);
      da = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 1) : $urandom_range(1, 4);
      plan(in, ia, 1'($urandom), da);
      go("random", in, 1000);
    end
    plan(32'hFC000015, 2, 0, 0);
    go("halt", 32'hFC000015, 1000);
    do_reset();
    plan(32'h00221020, 1, 0, 0);
    go("pre_abort_add", 32'h00221020, 1000);
    plan(32'h8C220004, 1, 0, 0);
    go("abort_lw", 32'h8C220004, 5);
    rst_n = 0;
    #1;
    chk("abort_outs", 0, 32'(sample()), 0);
    chk("abort_instret", 0, 32'(instret), 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    @(negedge clk);
    e = '0;
    e.ireq = 1;
    chk("after_release", 0, 32'(sample()), 32'(e));
    chk("after_release_instret", 0, 32'(instret), 0);
    $display("%0d/%0d checks passed", pass_n, tot);
    $finish;
  end
endmodule
